// File: rtl/router_pkt_fifo.sv
// Packet-aware output FIFO: {hdr_flag, data} storage with read-side sop/eop framing.
// Optional sticky overflow/underflow flags are built when ROUTER_PKT_FIFO_ERR_EN is defined.
module router_pkt_fifo #(
    parameter  int DATA_W       = 8,
    parameter  int DEPTH        = 16,
    parameter  int AFULL_THRESH = 14,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              sof_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              sop_out,
    output logic              eop_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic [ADDR_W:0]   hdr_count
`ifdef ROUTER_PKT_FIFO_ERR_EN
    ,
    output logic              ovf_err,
    output logic              udf_err
`endif
);

    localparam int              REM_W   = DATA_W - 1;
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AF_LVL  = (ADDR_W + 1)'(AFULL_THRESH);
    localparam logic [REM_W-1:0] REM_ONE = {{(REM_W - 1){1'b0}}, 1'b1};

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   hdr_cnt_q, hdr_cnt_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              flush;
    logic              wr_acc;
    logic              rd_acc;
    logic              hdr_in;
    logic              hdr_out;
    logic [DATA_W:0]   rd_word;

    assign flush   = !resetn || soft_reset;
    assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign almost_full = (level >= AF_LVL);
    assign wr_acc  = write_enb && !full;
    assign rd_acc  = read_enb && !empty;
    assign rd_word = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign hdr_in  = wr_acc && sof_in;
    assign hdr_out = rd_acc && rd_word[DATA_W];

    always_ff @(posedge clock) begin
        if (wr_acc && !flush) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {sof_in, data_in};
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        hdr_cnt_d = hdr_cnt_q;
        rem_d     = rem_q;
        dout_d    = dout_q;
        sop_d     = 1'b0;
        eop_d     = 1'b0;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (hdr_in && !hdr_out) hdr_cnt_d = hdr_cnt_q + PTR_ONE;
        if (hdr_out && !hdr_in) hdr_cnt_d = hdr_cnt_q - PTR_ONE;
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dout_d   = rd_word[DATA_W-1:0];
            // A header always restarts the tracker, even mid-packet; +1 covers the parity byte.
            if (rd_word[DATA_W]) begin
                sop_d = 1'b1;
                rem_d = {1'b0, rd_word[DATA_W-1:2]} + REM_ONE;
            end else if (rem_q != '0) begin
                rem_d = rem_q - REM_ONE;
                eop_d = (rem_q == REM_ONE);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            hdr_cnt_q <= '0;
            rem_q     <= '0;
            dout_q    <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            hdr_cnt_q <= hdr_cnt_d;
            rem_q     <= rem_d;
            dout_q    <= dout_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
        end
    end

    assign data_out  = dout_q;
    assign sop_out   = sop_q;
    assign eop_out   = eop_q;
    assign hdr_count = hdr_cnt_q;

`ifdef ROUTER_PKT_FIFO_ERR_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clock) begin
        if (flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q || (write_enb && full);
            udf_q <= udf_q || (read_enb && empty);
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed plus randomized bench for router_pkt_fifo, checked against a queue-based model.
module tb_router_pkt_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AFT    = 14;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              soft_reset = 1'b0;
    logic              write_enb = 1'b0;
    logic              sof_in = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              read_enb = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              sop_out;
    logic              eop_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [ADDR_W:0]   level;
    logic [ADDR_W:0]   hdr_count;
`ifdef ROUTER_PKT_FIFO_ERR_EN
    logic              ovf_err;
    logic              udf_err;
`endif

    router_pkt_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
        .write_enb(write_enb), .sof_in(sof_in), .data_in(data_in),
        .read_enb(read_enb), .data_out(data_out), .sop_out(sop_out),
        .eop_out(eop_out), .full(full), .empty(empty),
        .almost_full(almost_full), .level(level), .hdr_count(hdr_count)
`ifdef ROUTER_PKT_FIFO_ERR_EN
        , .ovf_err(ovf_err), .udf_err(udf_err)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: FIFO contents as a queue of {hdr_flag, data}.
    logic [DATA_W:0] mq[$];
    int              m_rem;
    logic [7:0]      m_dout;
    bit              m_sop, m_eop, m_ovf, m_udf;
    int              checks = 0;
    int              errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int hdrs();
        int n = 0;
        foreach (mq[i]) if (mq[i][DATA_W]) n++;
        return n;
    endfunction

    task automatic check_all(input string tag);
        int n = mq.size();
        chk({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
        chk({tag, ".sop"},      32'(sop_out),  32'(m_sop));
        chk({tag, ".eop"},      32'(eop_out),  32'(m_eop));
        chk({tag, ".level"},    32'(level),    32'(n));
        chk({tag, ".full"},     32'(full),     32'(n == DEPTH));
        chk({tag, ".empty"},    32'(empty),    32'(n == 0));
        chk({tag, ".afull"},    32'(almost_full), 32'(n >= AFT));
        chk({tag, ".hdrs"},     32'(hdr_count), 32'(hdrs()));
`ifdef ROUTER_PKT_FIFO_ERR_EN
        chk({tag, ".ovf"},      32'(ovf_err),  32'(m_ovf));
        chk({tag, ".udf"},      32'(udf_err),  32'(m_udf));
`endif
    endtask

    // One clock: drive, advance past the edge, update the model, compare everything.
    task automatic step(input bit we, input bit sof, input logic [7:0] din,
                        input bit re, input bit sr, input string tag);
        logic [DATA_W:0] w;
        bit pre_full, pre_empty;
        write_enb = we; sof_in = sof; data_in = din; read_enb = re; soft_reset = sr;
        @(posedge clock);
        #1;
        if (!resetn || sr) begin
            mq.delete();
            m_dout = 8'h00; m_sop = 0; m_eop = 0; m_rem = 0; m_ovf = 0; m_udf = 0;
        end else begin
            pre_full  = (mq.size() == DEPTH);
            pre_empty = (mq.size() == 0);
            m_sop = 0; m_eop = 0;
            if (we && pre_full) m_ovf = 1;
            if (re && pre_empty) m_udf = 1;
            if (re && !pre_empty) begin
                w = mq.pop_front();
                m_dout = w[7:0];
                if (w[DATA_W]) begin
                    m_sop = 1;
                    m_rem = int'(w[7:2]) + 1;
                end else if (m_rem > 0) begin
                    m_rem = m_rem - 1;
                    m_eop = (m_rem == 0);
                end
            end
            if (we && !pre_full) mq.push_back({sof, din});
        end
        check_all(tag);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] par;
        m_dout = 8'h00; m_sop = 0; m_eop = 0; m_rem = 0; m_ovf = 0; m_udf = 0;

        // Reset state
        resetn = 1'b0;
        step(0, 0, 8'h00, 0, 0, "reset");
        step(1, 1, 8'h77, 1, 0, "reset_hold");
        resetn = 1'b1;
        chk("reset.empty_const", 32'(empty), 32'd1);

        // 1: fill to full, drop overflow, drain in order
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 8'(i), 0, 0, "fill");
            if (i == 13) chk("afull_at13", 32'(almost_full), 32'd0);
            if (i == 14) chk("afull_at14", 32'(almost_full), 32'd1);
        end
        chk("full_at16", 32'(full), 32'd1);
        step(1, 0, 8'hFF, 0, 0, "ovf_write");
        chk("level_after_drop", 32'(level), 32'd16);
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 8'h00, 1, 0, "drain1");
            chk("drain1.order", 32'(data_out), 32'(i));
        end
        step(0, 0, 8'h00, 1, 0, "rd_empty");

        // 2: simultaneous read/write at full drops the write
        for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h40 + i), 0, 0, "fill2");
        step(1, 0, 8'hAA, 1, 0, "rw_full");
        chk("rw_full.head", 32'(data_out), 32'h40);
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 8'h00, 1, 0, "drain2");
            chk("drain2.no_AA", 32'(data_out != 8'hAA), 32'd1);
        end

        // 3: framed packet with 3-byte payload
        par = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;
        step(1, 1, 8'h0D, 0, 0, "pkt_hdr");
        step(1, 0, 8'h11, 0, 0, "pkt_p0");
        step(1, 0, 8'h22, 0, 0, "pkt_p1");
        step(1, 0, 8'h33, 0, 0, "pkt_p2");
        step(1, 0, par,   0, 0, "pkt_par");
        chk("pkt.hdr_count1", 32'(hdr_count), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 8'h00, 1, 0, "pkt_rd");
            chk("pkt_rd.sop_fixed", 32'(sop_out), 32'(i == 1));
            chk("pkt_rd.eop_fixed", 32'(eop_out), 32'(i == 5));
        end

        // 4: zero-length header, next read is eop
        step(1, 1, 8'h00, 0, 0, "z_hdr");
        step(1, 0, 8'h00, 0, 0, "z_par");
        step(0, 0, 8'h00, 1, 0, "z_rd1");
        step(0, 0, 8'h00, 1, 0, "z_rd2");
        chk("z_rd2.eop_fixed", 32'(eop_out), 32'd1);

        // 5: soft_reset mid-stream with read_enb high
        for (int i = 0; i < 10; i++) step(1, 0, 8'(8'h60 + i), 0, 0, "sr_fill");
        for (int i = 0; i < 4; i++)  step(0, 0, 8'h00, 1, 0, "sr_rd");
        step(0, 0, 8'h00, 1, 1, "soft_rst");
        chk("soft_rst.dout_fixed", 32'(data_out), 32'h00);
        step(1, 0, 8'h5A, 0, 0, "sr_wr");
        step(0, 0, 8'h00, 1, 0, "sr_rdback");
        chk("sr_rdback.fixed", 32'(data_out), 32'h5A);

        // 6: streaming at level 8, three wraps
        for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom), 0, 0, "st_pre");
        for (int i = 0; i < 48; i++) begin
            step(1, 0, 8'($urandom), 1, 0, "stream");
            chk("stream.nofull", 32'(full), 32'd0);
        end
        for (int i = 0; i < 9; i++) step(0, 0, 8'h00, 1, 0, "st_drain");
        step(0, 0, 8'h00, 0, 0, "st_idle");
        step(0, 0, 8'h00, 0, 1, "st_clr");

        // Randomized traffic with occasional headers and flushes
        for (int i = 0; i < 400; i++) begin
            d = 8'($urandom);
            step(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 3) == 0), d,
                 bit'($urandom_range(0, 99) < 50), bit'($urandom_range(0, 63) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
